recurrence_gen: RTL and testbench

Parametrised successor to the team's Fibonacci block. Computes term N of a general additive linear recurrence of order ORDER, with per-request seed terms, so Fibonacci, Lucas, tribonacci and similar sequences come from one block. The block fixes the restart hazard of the previous generation: IE always aborts cleanly and restarts. It adds BUSY and sticky overflow reporting. It sits in the same datapath as the existing sequence blocks and is driven by the same IE/OE handshake.

---
 rtl/recurrence_gen_if.sv | 16 +
 rtl/recurrence_gen.sv | 103 ++++++++++
 tb/tb_recurrence_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/recurrence_gen_if.sv
// Request/result bundle for recurrence_gen: index and seeds in, term and status out.
interface recurrence_gen_if #(
    parameter int BITS  = 32,
    parameter int ORDER = 2
);
    logic [BITS-1:0]       inp;
    logic                  ie;
    logic [ORDER*BITS-1:0] seeds;
    logic [BITS-1:0]       out;
    logic                  oe;
    logic                  busy;
    logic                  ovf;

    modport master (output inp, ie, seeds, input out, oe, busy, ovf);
    modport slave  (input inp, ie, seeds, output out, oe, busy, ovf);
endinterface

// File: rtl/recurrence_gen.sv
// Term N of an order-ORDER additive recurrence with per-request seeds.
// IE restarts from any state; OVF is sticky for the current request.
module recurrence_gen #(
    parameter int BITS  = 32,
    parameter int ORDER = 2
) (
    input  logic           clk,
    input  logic           rst,
    recurrence_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, state_n;
    logic [ORDER-1:0][BITS-1:0] win;
    logic [BITS-1:0]           cnt;
    logic [BITS-1:0]           n_lat;
    logic [BITS-1:0]           seed_sel;
    logic [BITS-1:0]           out_r;
    logic                      oe_r;
    logic                      ovf_r;
    logic [BITS+1:0]           sum;
    logic                      req_run;

    generate
        if (ORDER < 2 || ORDER > 4) begin : g_bad_order
            $error("recurrence_gen: ORDER must be in 2..4");
        end
    endgenerate

    assign req_run = (bus.inp >= BITS'(ORDER));

    // win[0] is the oldest term; two guard bits cover a sum of up to four terms.
    always_comb begin
        sum = '0;
        for (int i = 0; i < ORDER; i++)
            sum = sum + (BITS+2)'(win[i]);
    end

    always_comb begin
        seed_sel = '0;
        for (int i = 0; i < ORDER; i++)
            if (n_lat == BITS'(i))
                seed_sel = win[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.ie)
            state_n = req_run ? RUN : DONE;
        else if (state == RUN && cnt == BITS'(1))
            state_n = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win   <= '0;
            cnt   <= '0;
            n_lat <= '0;
            out_r <= '0;
            oe_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (bus.ie) begin
            for (int i = 0; i < ORDER; i++)
                win[i] <= bus.seeds[i*BITS +: BITS];
            n_lat <= bus.inp;
            cnt   <= req_run ? bus.inp - BITS'(ORDER - 1) : '0;
            oe_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    for (int i = 0; i < ORDER - 1; i++)
                        win[i] <= win[i+1];
                    win[ORDER-1] <= sum[BITS-1:0];
                    ovf_r <= ovf_r | (|sum[BITS+1:BITS]);
                    cnt   <= cnt - BITS'(1);
                    if (cnt == BITS'(1)) begin
                        out_r <= sum[BITS-1:0];
                        oe_r  <= 1'b1;
                    end
                end
                // DONE with OE low only follows a request with N < ORDER.
                DONE: begin
                    if (!oe_r) begin
                        out_r <= seed_sel;
                        oe_r  <= 1'b1;
                    end
                end
                default: oe_r <= 1'b0;
            endcase
        end
    end

    assign bus.out  = out_r;
    assign bus.oe   = oe_r;
    assign bus.ovf  = ovf_r;
    assign bus.busy = (state == RUN);
endmodule

// File: tb/tb_recurrence_gen.sv
// Directed bench for recurrence_gen: three instances cover Fibonacci/Lucas (32-bit),
// tribonacci (order 3) and 8-bit overflow behaviour.
module tb_recurrence_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    recurrence_gen_if #(.BITS(32), .ORDER(2)) i32 ();
    recurrence_gen_if #(.BITS(32), .ORDER(3)) i3  ();
    recurrence_gen_if #(.BITS(8),  .ORDER(2)) i8  ();

    recurrence_gen #(.BITS(32), .ORDER(2)) u32 (.clk(clk), .rst(rst), .bus(i32));
    recurrence_gen #(.BITS(32), .ORDER(3)) u3  (.clk(clk), .rst(rst), .bus(i3));
    recurrence_gen #(.BITS(8),  .ORDER(2)) u8  (.clk(clk), .rst(rst), .bus(i8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run32(input logic [31:0] n, input logic [63:0] sd, output int lat, output int bc);
        i32.inp = n; i32.seeds = sd; i32.ie = 1'b1;
        tick();
        i32.ie = 1'b0;
        chk("oe_clear32", {63'd0, i32.oe}, 64'd0);
        lat = 0; bc = 0;
        while (!i32.oe && lat < 400) begin
            if (i32.busy) bc++;
            tick();
            lat++;
        end
    endtask

    task automatic run3(input logic [31:0] n, input logic [95:0] sd, output int lat, output int bc);
        i3.inp = n; i3.seeds = sd; i3.ie = 1'b1;
        tick();
        i3.ie = 1'b0;
        chk("oe_clear3", {63'd0, i3.oe}, 64'd0);
        lat = 0; bc = 0;
        while (!i3.oe && lat < 400) begin
            if (i3.busy) bc++;
            tick();
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] n, input logic [15:0] sd, output int lat, output int bc);
        i8.inp = n; i8.seeds = sd; i8.ie = 1'b1;
        tick();
        i8.ie = 1'b0;
        chk("oe_clear8", {63'd0, i8.oe}, 64'd0);
        lat = 0; bc = 0;
        while (!i8.oe && lat < 400) begin
            if (i8.busy) bc++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bc;
        i32.inp = '0; i32.ie = 1'b0; i32.seeds = '0;
        i3.inp  = '0; i3.ie  = 1'b0; i3.seeds  = '0;
        i8.inp  = '0; i8.ie  = 1'b0; i8.seeds  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_oe",   {63'd0, i32.oe},   64'd0);
        chk("rst_busy", {63'd0, i32.busy}, 64'd0);
        chk("rst_ovf",  {63'd0, i32.ovf},  64'd0);
        chk("rst_out",  {32'd0, i32.out},  64'd0);
        rst = 1'b0;
        tick();

        // Fibonacci F(10)
        run32(32'd10, {32'd1, 32'd0}, lat, bc);
        chk("fib10_lat",  lat, 9);
        chk("fib10_busy", bc, 9);
        chk("fib10_out",  {32'd0, i32.out}, 64'd55);
        chk("fib10_ovf",  {63'd0, i32.ovf}, 64'd0);
        chk("fib10_bsy0", {63'd0, i32.busy}, 64'd0);
        repeat (3) tick();
        chk("done_hold_oe",  {63'd0, i32.oe}, 64'd1);
        chk("done_hold_out", {32'd0, i32.out}, 64'd55);

        // Lucas seeds (2,1)
        run32(32'd5, {32'd1, 32'd2}, lat, bc);
        chk("luc5_out", {32'd0, i32.out}, 64'd11);
        chk("luc5_lat", lat, 4);
        run32(32'd0, {32'd1, 32'd2}, lat, bc);
        chk("luc0_out",  {32'd0, i32.out}, 64'd2);
        chk("luc0_lat",  lat, 1);
        chk("luc0_busy", bc, 0);
        run32(32'd1, {32'd1, 32'd2}, lat, bc);
        chk("luc1_out", {32'd0, i32.out}, 64'd1);
        chk("luc1_lat", lat, 1);

        // Tribonacci-style 0,0,1
        run3(32'd7, {32'd1, 32'd0, 32'd0}, lat, bc);
        chk("tri7_out", {32'd0, i3.out}, 64'd13);
        chk("tri7_lat", lat, 5);
        chk("tri7_ovf", {63'd0, i3.ovf}, 64'd0);

        // 8-bit wrap and sticky overflow
        run8(8'd13, {8'd1, 8'd0}, lat, bc);
        chk("b8_13_out", {56'd0, i8.out}, 64'd233);
        chk("b8_13_ovf", {63'd0, i8.ovf}, 64'd0);
        chk("b8_13_lat", lat, 12);
        run8(8'd14, {8'd1, 8'd0}, lat, bc);
        chk("b8_14_out", {56'd0, i8.out}, 64'd121);
        chk("b8_14_ovf", {63'd0, i8.ovf}, 64'd1);
        repeat (2) tick();
        chk("b8_ovf_hold", {63'd0, i8.ovf}, 64'd1);
        run8(8'd3, {8'd1, 8'd0}, lat, bc);
        chk("b8_3_out", {56'd0, i8.out}, 64'd2);
        chk("b8_3_ovf", {63'd0, i8.ovf}, 64'd0);
        chk("b8_3_lat", lat, 2);
        run8(8'd255, {8'd1, 8'd0}, lat, bc);
        chk("b8_max_lat",  lat, 254);
        chk("b8_max_busy", bc, 254);

        // Abort: INP=20 replaced by INP=6 four cycles later
        i32.inp = 32'd20; i32.seeds = {32'd1, 32'd0}; i32.ie = 1'b1;
        tick();
        i32.ie = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_oe", {63'd0, i32.oe}, 64'd0);
        end
        run32(32'd6, {32'd1, 32'd0}, lat, bc);
        chk("abort_lat", lat, 5);
        chk("abort_out", {32'd0, i32.out}, 64'd8);

        // Asynchronous reset mid-run
        i32.inp = 32'd10; i32.ie = 1'b1;
        tick();
        i32.ie = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_oe",   {63'd0, i32.oe},   64'd0);
        chk("arst_busy", {63'd0, i32.busy}, 64'd0);
        chk("arst_ovf",  {63'd0, i32.ovf},  64'd0);
        chk("arst_out",  {32'd0, i32.out},  64'd0);
        #1 rst = 1'b0;
        tick();
        run32(32'd10, {32'd1, 32'd0}, lat, bc);
        chk("post_rst_out", {32'd0, i32.out}, 64'd55);
        chk("post_rst_lat", lat, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
